// File: rtl/multikey_debounce.sv
// N-channel active-low key debouncer: 2-FF synchroniser, stability filter, press/release pulses,
// long-press hold flag. Define KEY_AUTOREPEAT_EN to enable auto-repeat pulses on key_repeat.
module multikey_debounce #(
   parameter int unsigned NKEYS        = 4,
   parameter int unsigned STABLE_CNT   = 2,
   parameter int unsigned HOLD_TICKS   = 40,
   parameter int unsigned REPEAT_TICKS = 8
) (
   input  logic             sample_clk,
   input  logic             Reset_N,
   input  logic [NKEYS-1:0] keyin,
   output logic [NKEYS-1:0] keyout,
   output logic [NKEYS-1:0] key_press,
   output logic [NKEYS-1:0] key_release,
   output logic [NKEYS-1:0] key_hold,
   output logic [NKEYS-1:0] key_repeat
);

   localparam int unsigned SW = $clog2(STABLE_CNT + 1);
   localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
   localparam logic [SW-1:0] SC_LAST  = SW'(STABLE_CNT - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

   // Elaboration-time guard: every count parameter must be at least 1.
   if (STABLE_CNT < 1 || HOLD_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_params
      $error("multikey_debounce: STABLE_CNT, HOLD_TICKS and REPEAT_TICKS must be >= 1");
   end

`ifdef KEY_AUTOREPEAT_EN
   localparam int unsigned RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
   localparam logic [RW-1:0] R_LAST = RW'(REPEAT_TICKS - 1);
`endif

   for (genvar gi = 0; gi < NKEYS; gi++) begin : g_chan
      logic          s1_q, s2_q;
      logic          keyout_q, keyout_d;
      logic          press_q, press_d;
      logic          release_q, release_d;
      logic          hold_q, hold_d;
      logic [SW-1:0] scnt_q, scnt_d;
      logic [HW-1:0] hcnt_q, hcnt_d;

      always_comb begin
         keyout_d  = keyout_q;
         scnt_d    = '0;
         press_d   = 1'b0;
         release_d = 1'b0;
         // Any sample equal to the current level restarts the count.
         if (s2_q != keyout_q) begin
            if (scnt_q == SC_LAST) begin
               keyout_d  = s2_q;
               press_d   = ~s2_q;
               release_d = s2_q;
            end else begin
               scnt_d = scnt_q + SW'(1);
            end
         end

         if (keyout_q)
            hcnt_d = '0;
         else if (hcnt_q == HOLD_MAX)
            hcnt_d = hcnt_q;
         else
            hcnt_d = hcnt_q + HW'(1);
         // Look at the next count so the flag rises HOLD_TICKS edges after the press.
         hold_d = (hcnt_d == HOLD_MAX);
      end

      always_ff @(posedge sample_clk or negedge Reset_N) begin
         if (!Reset_N) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            keyout_q  <= 1'b1;
            scnt_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            hcnt_q    <= '0;
            hold_q    <= 1'b0;
         end else begin
            s1_q      <= keyin[gi];
            s2_q      <= s1_q;
            keyout_q  <= keyout_d;
            scnt_q    <= scnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            hcnt_q    <= hcnt_d;
            hold_q    <= hold_d;
         end
      end

      assign keyout[gi]      = keyout_q;
      assign key_press[gi]   = press_q;
      assign key_release[gi] = release_q;
      assign key_hold[gi]    = hold_q;

`ifdef KEY_AUTOREPEAT_EN
      logic          repeat_q, repeat_d;
      logic [RW-1:0] rcnt_q, rcnt_d;

      always_comb begin
         rcnt_d   = '0;
         repeat_d = 1'b0;
         // First pulse on the hold rising edge, then one per REPEAT_TICKS edges.
         if (hold_d) begin
            if (!hold_q || rcnt_q == R_LAST)
               repeat_d = 1'b1;
            else
               rcnt_d = rcnt_q + RW'(1);
         end
      end

      always_ff @(posedge sample_clk or negedge Reset_N) begin
         if (!Reset_N) begin
            rcnt_q   <= '0;
            repeat_q <= 1'b0;
         end else begin
            rcnt_q   <= rcnt_d;
            repeat_q <= repeat_d;
         end
      end

      assign key_repeat[gi] = repeat_q;
`else
      assign key_repeat[gi] = 1'b0;
`endif
   end

endmodule
